// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core sizing constants
package core_pkg;
    localparam int ROB_ENTRIES = 32;
endpackage

// File: rtl/rob_wb_arbiter.sv
// rtl/rob_wb_arbiter.sv - buffers per-unit completions and forwards up to two per cycle to the ROB
// Round-robin scan from rr_ptr picks two valid buffers; outputs are registered one cycle later.
module rob_wb_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int ROB_SIZE = core_pkg::ROB_ENTRIES,
    localparam int IDX_BITS = $clog2(ROB_SIZE)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][IDX_BITS-1:0]   req_rob_idx,
    input  logic [NUM_REQ-1:0]                 req_exception,
    input  logic                               flush_en,
    output logic                               mark_ready_en,
    output logic                               mark_ready_val,
    output logic                               mark_exception,
    output logic [IDX_BITS-1:0]                mark_ready_idx,
    output logic                               mark_ready_en1,
    output logic                               mark_ready_val1,
    output logic                               mark_exception1,
    output logic [IDX_BITS-1:0]                mark_ready_idx1,
    output logic [15:0]                        stall_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]               buf_valid_q, buf_valid_d;
    logic [NUM_REQ-1:0][IDX_BITS-1:0] buf_idx_q, buf_idx_d;
    logic [NUM_REQ-1:0]               buf_exc_q, buf_exc_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [15:0]                      stall_q, stall_d;
    logic                             en0_q, en0_d, exc0_q, exc0_d;
    logic                             en1_q, en1_d, exc1_q, exc1_d;
    logic [IDX_BITS-1:0]              idx0_q, idx0_d, idx1_q, idx1_d;

    logic                             arb_en;
    logic [NUM_REQ-1:0]               grant;
    logic [NUM_REQ-1:0]               accept;
    logic                             found0, found1;
    logic [PTR_W-1:0]                 sel0, sel1, last_sel, scan;
    int                               scan_int, next_int, valid_cnt;

    assign arb_en = !reset && !flush_en;

    always_comb begin
        grant    = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        sel0     = '0;
        sel1     = '0;
        last_sel = '0;
        scan     = '0;
        scan_int = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_int = int'(rr_ptr_q) + k;
            if (scan_int >= NUM_REQ) begin
                scan_int = scan_int - NUM_REQ;
            end
            scan = PTR_W'(scan_int);
            if (arb_en && buf_valid_q[scan] && !found1) begin
                grant[scan] = 1'b1;
                last_sel    = scan;
                if (!found0) begin
                    found0 = 1'b1;
                    sel0   = scan;
                end else begin
                    found1 = 1'b1;
                    sel1   = scan;
                end
            end
        end
    end

    // A granted buffer frees this cycle, so its unit may refill at the same edge.
    assign req_ready = {NUM_REQ{arb_en}} & (~buf_valid_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        buf_valid_d = flush_en ? '0 : ((buf_valid_q & ~grant) | accept);
        buf_idx_d   = buf_idx_q;
        buf_exc_d   = buf_exc_q;
        valid_cnt   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                buf_idx_d[i] = req_rob_idx[i];
                buf_exc_d[i] = req_exception[i];
            end
            valid_cnt = valid_cnt + (buf_valid_q[i] ? 1 : 0);
        end

        en0_d  = found0;
        idx0_d = found0 ? buf_idx_q[sel0] : '0;
        exc0_d = found0 & buf_exc_q[sel0];
        en1_d  = found1;
        idx1_d = found1 ? buf_idx_q[sel1] : '0;
        exc1_d = found1 & buf_exc_q[sel1];

        rr_ptr_d = rr_ptr_q;
        next_int = int'(last_sel) + 1;
        if (next_int >= NUM_REQ) begin
            next_int = 0;
        end
        if (found0) begin
            rr_ptr_d = PTR_W'(next_int);
        end

        stall_d = stall_q;
        if (!flush_en && valid_cnt >= 3 && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= '0;
            buf_idx_q   <= '0;
            buf_exc_q   <= '0;
            rr_ptr_q    <= '0;
            stall_q     <= '0;
            en0_q       <= 1'b0;
            idx0_q      <= '0;
            exc0_q      <= 1'b0;
            en1_q       <= 1'b0;
            idx1_q      <= '0;
            exc1_q      <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_exc_q   <= buf_exc_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_q     <= stall_d;
            en0_q       <= en0_d;
            idx0_q      <= idx0_d;
            exc0_q      <= exc0_d;
            en1_q       <= en1_d;
            idx1_q      <= idx1_d;
            exc1_q      <= exc1_d;
        end
    end

    assign mark_ready_en   = en0_q;
    assign mark_ready_val  = en0_q;
    assign mark_ready_idx  = idx0_q;
    assign mark_exception  = exc0_q;
    assign mark_ready_en1  = en1_q;
    assign mark_ready_val1 = en1_q;
    assign mark_ready_idx1 = idx1_q;
    assign mark_exception1 = exc1_q;
    assign stall_cnt       = stall_q;
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb/tb_rob_wb_arbiter.sv - scoreboard bench for rob_wb_arbiter
module tb_rob_wb_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int IDX_BITS = 5;

    logic                             clk;
    logic                             reset;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0][IDX_BITS-1:0] req_rob_idx;
    logic [NUM_REQ-1:0]               req_exception;
    logic                             flush_en;
    logic                             mark_ready_en, mark_ready_val, mark_exception;
    logic [IDX_BITS-1:0]              mark_ready_idx;
    logic                             mark_ready_en1, mark_ready_val1, mark_exception1;
    logic [IDX_BITS-1:0]              mark_ready_idx1;
    logic [15:0]                      stall_cnt;

    typedef struct {
        int                  port;
        logic [IDX_BITS-1:0] idx;
        logic                exc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cnt[NUM_REQ];

    rob_wb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_SIZE(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rob_idx     (req_rob_idx),
        .req_exception   (req_exception),
        .flush_en        (flush_en),
        .mark_ready_en   (mark_ready_en),
        .mark_ready_val  (mark_ready_val),
        .mark_exception  (mark_exception),
        .mark_ready_idx  (mark_ready_idx),
        .mark_ready_en1  (mark_ready_en1),
        .mark_ready_val1 (mark_ready_val1),
        .mark_exception1 (mark_exception1),
        .mark_ready_idx1 (mark_ready_idx1),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int port, input int idx, input logic exc);
        exp_t e;
        e.port = port;
        e.idx  = IDX_BITS'(idx);
        e.exc  = exc;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int port, input logic val, input logic [IDX_BITS-1:0] idx,
                           input logic exc);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq($sformatf("sb_underrun_p%0d", port), sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check_eq($sformatf("p%0d_port", port), port, e.port);
            check_eq($sformatf("p%0d_val", port), val, 1'b1);
            check_eq($sformatf("p%0d_idx", port), idx, e.idx);
            check_eq($sformatf("p%0d_exc", port), exc, e.exc);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mark_ready_en === 1'b1) begin
                pop_cmp(0, mark_ready_val, mark_ready_idx, mark_exception);
            end else begin
                check_eq("p0_idle_zero", {mark_ready_val, mark_exception, mark_ready_idx}, 0);
            end
            if (mark_ready_en1 === 1'b1) begin
                check_eq("p1_without_p0", mark_ready_en, 1'b1);
                pop_cmp(1, mark_ready_val1, mark_ready_idx1, mark_exception1);
            end else begin
                check_eq("p1_idle_zero", {mark_ready_val1, mark_exception1, mark_ready_idx1}, 0);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        req_rob_idx   = '0;
        req_exception = '0;
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while (sb.size() != 0 && guard < 12) begin
            cycle();
            guard++;
        end
        cycle();
        cycle();
        check_eq({"drain_", tag}, sb.size(), 0);
    endtask

    initial begin
        reset    = 1'b1;
        flush_en = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", req_ready, 4'h0);
        check_eq("rst_en0", mark_ready_en, 1'b0);
        check_eq("rst_en1", mark_ready_en1, 1'b0);
        check_eq("rst_idx0", mark_ready_idx, 0);
        check_eq("rst_stall", stall_cnt, 0);
        reset = 1'b0;
        #1;
        check_eq("idle_ready", req_ready, 4'hF);

        // single request from unit 2, then rr_ptr=3 puts unit 3 ahead of unit 0
        cycle();
        req_valid = 4'b0100; req_rob_idx[2] = 5'd5;
        push_exp(0, 5, 1'b0);
        cycle();
        idle_inputs();
        wait_drain("single");
        req_valid = 4'b1001; req_rob_idx[0] = 5'd6; req_rob_idx[3] = 5'd9;
        push_exp(0, 9, 1'b0);
        push_exp(1, 6, 1'b0);
        cycle();
        idle_inputs();
        wait_drain("rr3");

        // four simultaneous requests from rr_ptr=0
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req_valid = 4'hF;
        for (int u = 0; u < NUM_REQ; u++) req_rob_idx[u] = IDX_BITS'(u + 1);
        push_exp(0, 1, 1'b0); push_exp(1, 2, 1'b0);
        push_exp(0, 3, 1'b0); push_exp(1, 4, 1'b0);
        cycle();
        idle_inputs();
        #1;
        check_eq("four_ready", req_ready, 4'b0011);
        wait_drain("four");
        check_eq("four_stall", stall_cnt, 1);

        // fairness: every unit streams four completions
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 0 * 4 + k, 1'b0); push_exp(1, 1 * 4 + k, 1'b0);
            push_exp(0, 2 * 4 + k, 1'b0); push_exp(1, 3 * 4 + k, 1'b0);
        end
        for (int u = 0; u < NUM_REQ; u++) cnt[u] = 0;
        for (int g = 0; g < 40; g++) begin
            logic [NUM_REQ-1:0] acc;
            for (int u = 0; u < NUM_REQ; u++) begin
                req_valid[u]   = (cnt[u] < 4);
                req_rob_idx[u] = IDX_BITS'(u * 4 + cnt[u]);
            end
            #1;
            acc = req_valid & req_ready;
            cycle();
            for (int u = 0; u < NUM_REQ; u++) if (acc[u]) cnt[u]++;
            if (cnt[0] == 4 && cnt[1] == 4 && cnt[2] == 4 && cnt[3] == 4) break;
        end
        idle_inputs();
        for (int u = 0; u < NUM_REQ; u++) check_eq($sformatf("fair_acc%0d", u), cnt[u], 4);
        wait_drain("fair");
        check_eq("fair_stall", stall_cnt, 8);

        // back-to-back refill on unit 0
        for (int k = 0; k < 6; k++) begin
            req_valid = 4'b0001; req_rob_idx[0] = IDX_BITS'(10 + k);
            push_exp(0, 10 + k, 1'b0);
            #1;
            check_eq($sformatf("b2b_ready%0d", k), req_ready[0], 1'b1);
            cycle();
        end
        idle_inputs();
        wait_drain("b2b");

        // flush with buffers 1 and 3 pending; rr_ptr stays at 1
        req_valid = 4'b1010; req_rob_idx[1] = 5'd20; req_rob_idx[3] = 5'd21;
        cycle();
        idle_inputs();
        flush_en = 1'b1;
        #1;
        check_eq("flush_ready", req_ready, 4'h0);
        cycle();
        flush_en = 1'b0;
        #1;
        check_eq("flush_en0", mark_ready_en, 1'b0);
        check_eq("flush_en1", mark_ready_en1, 1'b0);
        check_eq("post_flush_ready", req_ready, 4'hF);
        req_valid = 4'b0011; req_rob_idx[0] = 5'd22; req_rob_idx[1] = 5'd23;
        push_exp(0, 23, 1'b0);
        push_exp(1, 22, 1'b0);
        cycle();
        idle_inputs();
        wait_drain("flush");

        // exception forwarding, then reset with two buffers pending
        req_valid = 4'b0010; req_rob_idx[1] = 5'd7; req_exception[1] = 1'b1;
        push_exp(0, 7, 1'b1);
        cycle();
        idle_inputs();
        wait_drain("exc");
        req_valid = 4'b1100; req_rob_idx[2] = 5'd8; req_rob_idx[3] = 5'd9;
        cycle();
        reset = 1'b1; flush_en = 1'b1; req_valid = 4'b0011;
        #1;
        check_eq("rst_mid_ready", req_ready, 4'h0);
        cycle();
        reset = 1'b0; flush_en = 1'b0;
        idle_inputs();
        #1;
        check_eq("rst_mid_en0", mark_ready_en, 1'b0);
        check_eq("rst_mid_en1", mark_ready_en1, 1'b0);
        check_eq("rst_mid_stall", stall_cnt, 0);
        check_eq("rst_mid_ready_after", req_ready, 4'hF);
        wait_drain("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rob_wb_arbiter.md
ROB_WB_ARBITER -- requirements
Module: rob_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of completing execution units (ALU0, ALU1, LSU, BRU).
REQ-002 SHALL have parameter ROB_SIZE, default core_pkg::ROB_ENTRIES, meaning ROB depth; IDX_BITS = $clog2(ROB_SIZE).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, completion request per unit.
REQ-006 SHALL have port req_ready, output, NUM_REQ, unit's request is accepted this cycle when valid&ready.
REQ-007 SHALL have port req_rob_idx, input, NUM_REQ x IDX_BITS, ROB index completed by each unit.
REQ-008 SHALL have port req_exception, input, NUM_REQ, completion carries an exception.
REQ-009 SHALL have port flush_en, input, 1, pipeline flush; discard all pending completions.
REQ-010 SHALL have ports mark_ready_en, mark_ready_val, mark_exception (1 each) and mark_ready_idx (IDX_BITS), outputs, ROB completion port 0.
REQ-011 SHALL have ports mark_ready_en1, mark_ready_val1, mark_exception1 (1 each) and mark_ready_idx1 (IDX_BITS), outputs, ROB completion port 1.
REQ-012 SHALL have port stall_cnt, output, 16, saturating count of cycles in which a buffered completion lost arbitration.

Function
REQ-013 SHALL hold one buffer entry per requester (buf_valid, buf_idx, buf_exc).
REQ-014 SHALL drive req_ready[i] = !flush_en & (!buf_valid[i] | grant[i]), combinationally.
REQ-015 SHALL on valid&ready at edge E capture req_rob_idx/req_exception into buffer i, buf_valid[i] <= 1.
REQ-016 SHALL each cycle grant up to 2 valid buffers, scanning round-robin from rr_ptr upward modulo NUM_REQ; first found -> port 0, second -> port 1.
REQ-017 SHALL clear buf_valid of granted entries at the same edge unless refilled per REQ-014 (refill wins).
REQ-018 SHALL register port outputs: grant evaluated in cycle C appears on mark_ready_* during cycle C+1; acceptance-to-ROB-mark latency 2 cycles (accept edge E, outputs valid after edge E+1).
REQ-019 SHALL drive mark_ready_val = mark_ready_en and mark_ready_val1 = mark_ready_en1; idx/exception from the granted buffer; unused port outputs all zero.
REQ-020 SHALL update rr_ptr <= (last granted requester + 1) mod NUM_REQ when any grant occurs; unchanged otherwise.
REQ-021 SHALL with only one valid buffer use port 0 only; port 1 en = 0.
REQ-022 SHALL on flush_en: clear all buf_valid, accept nothing, grant nothing, register all mark_ready_* outputs to 0 for the next cycle; rr_ptr and stall_cnt retained.
REQ-023 SHALL increment stall_cnt when ≥3 buffers are valid and flush_en = 0, saturating at 16'hFFFF.
REQ-024 SHALL not check or merge duplicate ROB indices; both are forwarded.

Reset
REQ-025 SHALL on reset clear all buf_valid, buf_idx, buf_exc, rr_ptr = 0, stall_cnt = 0, all mark_ready_* outputs = 0; reset mid-stream drops pending completions and has priority over flush_en and requests.
REQ-026 SHALL hold req_ready = 0 while reset is asserted.

Verification
REQ-027 Single request: unit 2 valid, idx=5, exc=0 at edge E -> after E+1 mark_ready_en=1, idx=5, val=1, exception=0; en1=0; rr_ptr=3.
REQ-028 Four simultaneous requests idx 1,2,3,4, rr_ptr=0 -> cycle 1 port0=1, port1=2; next cycle port0=3, port1=4; stall_cnt=1.
REQ-029 Fairness: all units request continuously for 8 cycles -> each unit granted exactly 4 times, order 0,1 / 2,3 / 0,1 ...
REQ-030 Back-to-back refill: unit 0 valid every cycle, alone -> req_ready stays 1, one port-0 mark per cycle, consecutive idx preserved.
REQ-031 Flush: buffers 1 and 3 valid, flush_en=1 -> next cycle all mark_ready_en=0, buffers empty, req_ready=0 during flush cycle, rr_ptr unchanged.
REQ-032 Exception and reset: unit 1 idx=7 exc=1 -> mark_exception=1 with idx=7; reset asserted with 2 buffers valid -> next cycle all outputs 0, stall_cnt=0.
